// File: rtl/logic_unit_8bit_hs_if.sv
// Handshake bundle for the logic unit: an input channel carrying operands and
// opcode, and an output channel carrying the result, its zero flag and the
// completed-operation counter.
interface logic_unit_8bit_hs_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int CNT_WIDTH   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  a_in;
  logic [DATA_WIDTH-1:0]  b_in;
  logic [OPCODE_SIZE-1:0] opcode_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  y_out;
  logic                   zero_out;
  logic [CNT_WIDTH-1:0]   op_count;

  // Upstream driver / downstream consumer side
  modport master (
    output in_valid, a_in, b_in, opcode_in, out_ready,
    input  in_ready, out_valid, y_out, zero_out, op_count
  );

  // Logic unit side
  modport slave (
    input  in_valid, a_in, b_in, opcode_in, out_ready,
    output in_ready, out_valid, y_out, zero_out, op_count
  );
endinterface

// File: rtl/logic_unit_8bit_hs.sv
// Handshaked bitwise logic unit with a 2-entry result FIFO and a counter of
// results consumed downstream.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | no result buffered, out_valid=0, in_ready=1
// S_ONE   | one result at head, out_valid=1, in_ready=1
// S_FULL  | head plus one queued in tail, in_ready=0
//
// The FIFO is a head/tail pair: the head register always drives y_out, so a
// held output under backpressure is just an unchanged register. in_ready is
// decoded from the state register only, never from out_ready.
module logic_unit_8bit_hs #(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_SIZE = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  logic_unit_8bit_hs_if.slave bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;
  logic [DATA_WIDTH-1:0] w_result;
  logic [CNT_WIDTH-1:0]  r_op_count;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_out_valid;

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_push      = bus.in_valid && (r_state != S_FULL);
  assign w_pop       = bus.out_ready && w_out_valid;

  // Bitwise result of the operands presented on the input channel
  always_comb begin
    w_result = '0;
    case (bus.opcode_in)
      2'b00:   w_result = bus.a_in & bus.b_in;
      2'b01:   w_result = bus.a_in | bus.b_in;
      2'b10:   w_result = bus.a_in ^ bus.b_in;
      default: w_result = ~bus.a_in;
    endcase
  end

  // Next state and FIFO register updates for push/pop combinations
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_head_nxt  = w_result;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          // old head leaves, the new result takes its place
          w_head_nxt = w_result;
        end else if (w_push) begin
          w_tail_nxt  = w_result;
          w_state_nxt = S_FULL;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (w_pop) begin
          w_head_nxt  = r_tail;
          w_state_nxt = S_ONE;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // State and buffer registers; reset discards anything buffered
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  // Consumed-result counter, wraps naturally at its width
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  // The head may hold a stale value after draining, so mask it when empty
  assign bus.in_ready  = (r_state != S_FULL);
  assign bus.out_valid = w_out_valid;
  assign bus.y_out     = w_out_valid ? r_head : '0;
  assign bus.zero_out  = w_out_valid && (r_head == '0);
  assign bus.op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_8bit_hs.sv
// Directed and randomised checks of the handshaked logic unit: opcode results,
// backpressure hold, simultaneous push/pop, reset flush, counter wrap on a
// narrow-counter build, and a scoreboarded random valid/ready run.
module tb_logic_unit_8bit_hs;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic_unit_8bit_hs_if #(.DATA_WIDTH(8), .OPCODE_SIZE(2), .CNT_WIDTH(16)) bus0 ();
  logic_unit_8bit_hs_if #(.DATA_WIDTH(8), .OPCODE_SIZE(2), .CNT_WIDTH(4))  bus1 ();

  logic_unit_8bit_hs #(.DATA_WIDTH(8), .OPCODE_SIZE(2), .CNT_WIDTH(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  logic_unit_8bit_hs #(.DATA_WIDTH(8), .OPCODE_SIZE(2), .CNT_WIDTH(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  logic [7:0] q[$];
  int         pushed;
  int         cycles;
  logic       fire_in;
  logic       fire_out;
  logic       hold;
  logic [7:0] prev_y;
  logic [7:0] exp_y;

  initial begin
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b0;
    bus0.a_in = 8'h00; bus0.b_in = 8'h00; bus0.opcode_in = 2'b00;
    bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    bus1.a_in = 8'h00; bus1.b_in = 8'h00; bus1.opcode_in = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_out_valid", bus0.out_valid, 1'b0);
    chk("rst_y_out",     bus0.y_out,     8'h00);
    chk("rst_zero_out",  bus0.zero_out,  1'b0);
    chk("rst_op_count",  bus0.op_count,  16'd0);
    chk("rst_in_ready",  bus0.in_ready,  1'b1);

    // each opcode, one cycle after accept, streaming with out_ready=1
    bus0.out_ready = 1'b1;
    bus0.in_valid  = 1'b1;
    bus0.a_in = 8'hF0; bus0.b_in = 8'h3C; bus0.opcode_in = 2'b00;
    @(negedge clk);
    chk("and_valid", bus0.out_valid, 1'b1);
    chk("and_y",     bus0.y_out,     8'h30);
    bus0.opcode_in = 2'b01;
    @(negedge clk);
    chk("or_y",      bus0.y_out,     8'hFC);
    bus0.opcode_in = 2'b10;
    @(negedge clk);
    chk("xor_y",     bus0.y_out,     8'hCC);
    bus0.opcode_in = 2'b11;
    @(negedge clk);
    chk("not_y",     bus0.y_out,     8'h0F);
    chk("not_cnt",   bus0.op_count,  16'd3);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("t1_empty",  bus0.out_valid, 1'b0);
    chk("t1_cnt",    bus0.op_count,  16'd4);

    // backpressure: fill both entries, head must hold
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.a_in = 8'hAA; bus0.b_in = 8'h55; bus0.opcode_in = 2'b00;
    @(negedge clk);
    chk("bp1_y",     bus0.y_out,    8'h00);
    chk("bp1_zero",  bus0.zero_out, 1'b1);
    chk("bp1_ready", bus0.in_ready, 1'b1);
    bus0.a_in = 8'h01; bus0.b_in = 8'h02; bus0.opcode_in = 2'b01;
    @(negedge clk);
    chk("bp2_ready", bus0.in_ready, 1'b0);
    chk("bp2_y",     bus0.y_out,    8'h00);
    chk("bp2_zero",  bus0.zero_out, 1'b1);
    bus0.a_in = 8'hFF; bus0.b_in = 8'h00; bus0.opcode_in = 2'b01;
    @(negedge clk);
    chk("bp3_y",     bus0.y_out,    8'h00);
    chk("bp3_zero",  bus0.zero_out, 1'b1);
    chk("bp3_ready", bus0.in_ready, 1'b0);
    @(negedge clk);
    chk("bp4_y",     bus0.y_out,    8'h00);
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("bp5_y",     bus0.y_out,    8'h03);
    chk("bp5_zero",  bus0.zero_out, 1'b0);
    chk("bp5_cnt",   bus0.op_count, 16'd5);
    @(negedge clk);
    chk("bp6_valid", bus0.out_valid, 1'b0);
    chk("bp6_y",     bus0.y_out,     8'h00);
    chk("bp6_zero",  bus0.zero_out,  1'b0);
    chk("bp6_cnt",   bus0.op_count,  16'd6);
    @(negedge clk);
    chk("bp7_valid", bus0.out_valid, 1'b0);

    // simultaneous push and pop at count=1
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.a_in = 8'hF0; bus0.b_in = 8'h00; bus0.opcode_in = 2'b11;
    @(negedge clk);
    chk("pp_head",   bus0.y_out,    8'h0F);
    bus0.a_in = 8'hFF; bus0.b_in = 8'hFF; bus0.opcode_in = 2'b10;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    chk("pp_y",      bus0.y_out,     8'h00);
    chk("pp_zero",   bus0.zero_out,  1'b1);
    chk("pp_valid",  bus0.out_valid, 1'b1);
    chk("pp_ready",  bus0.in_ready,  1'b1);
    chk("pp_cnt",    bus0.op_count,  16'd7);
    bus0.in_valid = 1'b0;
    @(negedge clk);
    chk("pp_drain",  bus0.out_valid, 1'b0);
    chk("pp_cnt2",   bus0.op_count,  16'd8);

    // reset with two results buffered
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.a_in = 8'h12; bus0.b_in = 8'h34; bus0.opcode_in = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk("rf_full",   bus0.in_ready, 1'b0);
    bus0.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rf_valid",  bus0.out_valid, 1'b0);
    chk("rf_ready",  bus0.in_ready,  1'b1);
    chk("rf_cnt",    bus0.op_count,  16'd0);
    chk("rf_y",      bus0.y_out,     8'h00);
    bus0.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rf_stale",  bus0.out_valid, 1'b0);
    chk("rf_cnt2",   bus0.op_count,  16'd0);

    // 4-bit counter wraps after 16 pops, reads 1 after 17
    bus1.out_ready = 1'b1;
    bus1.in_valid  = 1'b1;
    bus1.a_in = 8'h0F; bus1.b_in = 8'hF0; bus1.opcode_in = 2'b01;
    repeat (17) @(negedge clk);
    chk("wrap_cnt16", bus1.op_count, 4'd0);
    chk("wrap_y",     bus1.y_out,    8'hFF);
    bus1.in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_cnt17", bus1.op_count,  4'd1);
    chk("wrap_empty", bus1.out_valid, 1'b0);
    bus1.out_ready = 1'b0;

    // random valid/ready traffic against a queue model
    bus0.in_valid = 1'b0;
    bus0.out_ready = 1'b0;
    pushed = 0;
    cycles = 0;
    hold   = 1'b0;
    prev_y = 8'h00;
    while ((pushed < 1000 || q.size() != 0) && cycles < 20000) begin
      chk("rnd_valid", bus0.out_valid, (q.size() != 0));
      chk("rnd_ready", bus0.in_ready,  (q.size() < 2));
      if (q.size() != 0) begin
        chk("rnd_y",    bus0.y_out,    q[0]);
        chk("rnd_zero", bus0.zero_out, (q[0] == 8'h00));
      end
      if (hold) chk("rnd_stable", bus0.y_out, prev_y);
      bus0.in_valid  = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      bus0.a_in      = 8'($urandom_range(0, 255));
      bus0.b_in      = 8'($urandom_range(0, 255));
      bus0.opcode_in = 2'($urandom_range(0, 3));
      bus0.out_ready = ($urandom_range(0, 2) != 0);
      fire_in  = bus0.in_valid && bus0.in_ready;
      fire_out = bus0.out_valid && bus0.out_ready;
      exp_y    = model(bus0.a_in, bus0.b_in, bus0.opcode_in);
      hold     = bus0.out_valid && !bus0.out_ready;
      prev_y   = bus0.y_out;
      @(posedge clk);
      if (fire_out) void'(q.pop_front());
      if (fire_in) begin
        q.push_back(exp_y);
        pushed++;
      end
      @(negedge clk);
      cycles++;
    end
    chk("rnd_pushed", pushed, 1000);
    chk("rnd_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
